// File: rtl/fc_stream_engine_pkg.sv
// Shared definitions for the streaming NN layers (fc, conv, pooling):
// controller state encoding, default data format and saturation bounds.
package fc_stream_engine_pkg;

  // state    | meaning
  // ST_IDLE  | waiting for start, busy low
  // ST_LOAD  | accepting the activation vector into the buffer
  // ST_MAC   | accepting one weight row, accumulating act[k]*w
  // ST_EMIT  | presenting one neuron result until out_ready
  // ST_FIN   | one-cycle done pulse
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_EMIT,
    ST_FIN
  } fc_state_t;

  localparam int FC_DATA_W_DEF    = 32;
  localparam int FC_FRAC_BITS_DEF = 16;

  // Output saturation bounds for the default data width.
  localparam logic [FC_DATA_W_DEF-1:0] FC_SAT_MAX_DEF = {1'b0, {(FC_DATA_W_DEF-1){1'b1}}};
  localparam logic [FC_DATA_W_DEF-1:0] FC_SAT_MIN_DEF = {1'b1, {(FC_DATA_W_DEF-1){1'b0}}};

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int fc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Output stage: arithmetic shift of the accumulator by FRAC_BITS (floor),
// saturation to the signed DATA_W range, and optional ReLU.
// Macro FC_STREAM_RELU_EN: when defined, negative results are clamped to 0.
module fc_requant
  import fc_stream_engine_pkg::*;
#(
  parameter int ACC_W     = 2 * FC_DATA_W_DEF + 6,
  parameter int DATA_W    = FC_DATA_W_DEF,
  parameter int FRAC_BITS = FC_FRAC_BITS_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] q
);

  localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic        [DATA_W-1:0] sat;

  // Shift, clamp to the output range, then apply the optional ReLU.
  always_comb begin
    shifted = $signed(acc) >>> FRAC_BITS;
    if (shifted > HI) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < LO) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = shifted[DATA_W-1:0];
    end
`ifdef FC_STREAM_RELU_EN
    q = sat[DATA_W-1] ? '0 : sat;
`else
    q = sat;
`endif
  end

endmodule

// File: rtl/fc_stream_engine.sv
// Streaming fully-connected layer: buffers IN_SIZE activations, then for each
// of NUM_OUT neurons consumes one weight row, accumulates and emits a result.
// Macro FC_STREAM_RELU_EN (in fc_requant) selects ReLU on the outputs.
module fc_stream_engine
  import fc_stream_engine_pkg::*;
#(
  parameter int IN_SIZE   = 64,
  parameter int NUM_OUT   = 10,
  parameter int DATA_W    = FC_DATA_W_DEF,
  parameter int FRAC_BITS = FC_FRAC_BITS_DEF,
  localparam int OUT_W    = fc_idx_w(NUM_OUT)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OUT_W-1:0]  out_idx
);

  localparam int K_W   = fc_idx_w(IN_SIZE);
  localparam int ACC_W = 2 * DATA_W + K_W;

  fc_state_t state, state_nxt;

  logic        [K_W-1:0]      ld_cnt;
  logic        [K_W-1:0]      k_cnt;
  logic        [OUT_W-1:0]    j_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   act_mem [IN_SIZE];
  logic        [2*DATA_W-1:0] act_ext;
  logic        [2*DATA_W-1:0] w_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;
  logic                       ld_last;
  logic                       k_last;
  logic                       j_last;
  logic        [DATA_W-1:0]   q;

  assign ld_last = (ld_cnt == K_W'(IN_SIZE - 1));
  assign k_last  = (k_cnt == K_W'(IN_SIZE - 1));
  assign j_last  = (j_cnt == OUT_W'(NUM_OUT - 1));

  // Both operands are sign-extended so the truncated product is the full signed product.
  assign act_ext  = {{DATA_W{act_mem[k_cnt][DATA_W-1]}}, act_mem[k_cnt]};
  assign w_ext    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
  assign prod     = $signed(act_ext) * $signed(w_ext);
  assign prod_ext = {{K_W{prod[2*DATA_W-1]}}, prod};

  fc_requant #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_requant (
    .acc(acc),
    .q  (q)
  );

  assign out_data = out_valid ? q : '0;
  assign out_idx  = j_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs; stalls simply hold the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    in_ready  = 1'b0;
    w_ready   = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && ld_last) state_nxt = ST_MAC;
      end
      ST_MAC: begin
        w_ready = 1'b1;
        if (w_valid && k_last) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = j_last ? ST_FIN : ST_MAC;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters and accumulator advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (rstb) begin
      ld_cnt <= '0;
      k_cnt  <= '0;
      j_cnt  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ld_cnt <= '0;
            k_cnt  <= '0;
            j_cnt  <= '0;
            acc    <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) ld_cnt <= ld_last ? '0 : ld_cnt + K_W'(1);
        end
        ST_MAC: begin
          if (w_valid) begin
            acc   <= acc + $signed(prod_ext);
            k_cnt <= k_last ? '0 : k_cnt + K_W'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            acc <= '0;
            if (!j_last) j_cnt <= j_cnt + OUT_W'(1);
          end
        end
        ST_FIN: begin
          j_cnt <= '0;
        end
        default: begin
          acc <= '0;
        end
      endcase
    end
  end

  // Activation buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rstb && state == ST_LOAD && in_valid) begin
      act_mem[ld_cnt] <= in_data;
    end
  end

endmodule

// File: doc/fc_stream_engine.md
FC_STREAM_ENGINE -- requirements
Module: fc_stream_engine

Interface
REQ-001 SHALL have parameter IN_SIZE, default 64, number of input activations per inference.
REQ-002 SHALL have parameter NUM_OUT, default 10, number of output neurons.
REQ-003 SHALL have parameter DATA_W, default 32, signed fixed-point activation/weight/output width.
REQ-004 SHALL have parameter FRAC_BITS, default 16, fractional bits of all data words.
REQ-005 SHALL have ports: clk  in  1  clock; rstb  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  begin inference; busy  out  1  inference in progress; done  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  DATA_W  activation stream.
REQ-008 SHALL have ports: w_valid  in  1; w_ready  out  1; w_data  in  DATA_W  weight stream, row-major (neuron j, inputs 0..IN_SIZE-1).
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_W  neuron result; out_idx  out  clog2(NUM_OUT)  neuron index.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, MAC, EMIT, FIN.
REQ-011 IDLE: start=1 SHALL move to LOAD next cycle; busy=0 only in IDLE.
REQ-012 LOAD: in_ready=1; each in_valid&in_ready SHALL store in_data into activation buffer at index 0..IN_SIZE-1; after index IN_SIZE-1 accepted SHALL go to MAC with neuron j=0.
REQ-013 MAC: w_ready=1; each w_valid&w_ready SHALL add act[k]*w_data (full 2*DATA_W signed product) into a signed accumulator of 2*DATA_W+clog2(IN_SIZE) bits, k incrementing; accumulator cleared at start of each neuron.
REQ-014 After weight k=IN_SIZE-1 accepted, SHALL enter EMIT next cycle with out_valid=1.
REQ-015 out_data SHALL be accumulator arithmetically shifted right by FRAC_BITS (truncation toward minus infinity), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-016 EMIT: out_valid, out_data, out_idx SHALL hold stable until out_ready=1; on handshake, SHALL go to MAC for j+1, or FIN if j=NUM_OUT-1.
REQ-017 FIN: done=1 for exactly one cycle, then IDLE.
REQ-018 in_ready SHALL be 0 outside LOAD and w_ready 0 outside MAC; stream beats offered then SHALL be ignored.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 Stalls (in_valid=0, w_valid=0, out_ready=0) SHALL freeze all counters and accumulator without data loss.
REQ-021 Throughput SHALL be one MAC per cycle when w_valid=1 continuously.

Reset
REQ-022 rstb=1 at any clock edge, including mid-LOAD/MAC/EMIT, SHALL return to IDLE and abandon the inference.
REQ-023 Reset values: busy=0, done=0, in_ready=0, w_ready=0, out_valid=0, out_data=0, out_idx=0, all counters and accumulator 0; activation buffer contents need not be reset.

Configuration
REQ-024 Macro FC_STREAM_RELU_EN defined: out_data SHALL be max(0, saturated result); undefined: saturated result output unmodified (negative values pass).

Structure
REQ-025 Shared package SHALL hold the FSM state enum, DATA_W/FRAC_BITS defaults and saturation-bound constants, shared with conv and pooling layers.
REQ-026 Saturate/shift/optional-ReLU output stage SHALL be a sub-module fc_requant (combinational, parametrised on accumulator and DATA_W).

Verification
REQ-027 IN_SIZE=4, NUM_OUT=2: acts 4x0x00010000, weights 0x00008000 all -> out_idx 0,1 each out_data 0x00020000, then done pulse.
REQ-028 Acts 4x0x7FFF0000, weights 4x0x00010000 -> out_data 0x7FFFFFFF (saturated); weights 4x0xFFFF0000 -> 0x80000000 without macro, 0x00000000 with FC_STREAM_RELU_EN.
REQ-029 out_ready held low 5 cycles in EMIT -> out_valid/out_data/out_idx stable all 5 cycles, w_ready=0, single result delivered.
REQ-030 w_valid toggled randomly 50% -> results identical to continuous stream; in_valid asserted in MAC -> in_ready=0, no buffer change.
REQ-031 rstb pulsed mid-MAC (j=1, k=2) -> next cycle busy=0, out_valid=0; fresh start produces correct results from k=0.
REQ-032 start asserted during LOAD -> ignored; exactly one done pulse per accepted start.
